// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: fetch/decode/execute sequencer driving the ALU control interface
// Ports: clk_pi/reset_n_pi (sync, active-low); instr_req_po/instr_addr_po/instr_valid_pi/instr_pi
// fetch handshake; ALU strobes, alu_func_po, immediate_po, rd/rs1/rs2_po decoded fields;
// carry/borrow_flag_po architectural flags fed from alu_carry/borrow_pi; rf_we_po, mem_rd/wr_po,
// branch_po side strobes; halted_po after HALT.
module alu_ctrl_seq #(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_pi,
  input  logic            reset_n_pi,
  output logic            instr_req_po,
  output logic [PC_W-1:0] instr_addr_po,
  input  logic            instr_valid_pi,
  input  logic [15:0]     instr_pi,
  output logic            arith_1op_po,
  output logic            arith_2op_po,
  output logic            addi_po,
  output logic            subi_po,
  output logic            load_or_store_po,
  output logic            stc_cmd_po,
  output logic            stb_cmd_po,
  output logic [2:0]      alu_func_po,
  output logic [5:0]      immediate_po,
  output logic [2:0]      rd_po,
  output logic [2:0]      rs1_po,
  output logic [2:0]      rs2_po,
  output logic            carry_flag_po,
  output logic            borrow_flag_po,
  input  logic            alu_carry_pi,
  input  logic            alu_borrow_pi,
  output logic            rf_we_po,
  output logic            mem_rd_po,
  output logic            mem_wr_po,
  output logic            branch_po,
  output logic            halted_po
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALTED} state_t;
  state_t state, state_nx;
  logic [PC_W-1:0] pc;
  logic [15:0] ir;
  logic carry_q, borrow_q;
  logic [10:0] strb_q, strb_d;
  logic [3:0] op;
  logic [11:0] ctl;
  logic is_ctl, ctl_rst, ctl_halt, cap_c, cap_b;
  always_comb begin
    op = ir[15:12];
    ctl = ir[11:0];
    is_ctl = op == 4'hf;
    ctl_rst = is_ctl && ctl == 12'haaa;
    ctl_halt = is_ctl && ctl == 12'hfff;
    // {arith_1op, arith_2op, addi, subi, ls, stc, stb, rf_we, mem_rd, mem_wr, branch}
    strb_d = {op == 4'h2, op == 4'h1, op == 4'h4, op == 4'h5, op == 4'h6 || op == 4'h7,
              is_ctl && ctl == 12'h001, is_ctl && ctl == 12'h002, op inside {[4'h1:4'h5]},
              op == 4'h6, op == 4'h7, op inside {[4'h8:4'hc]}};
    // 2op funcs 000/001 are ADD/ADDC, 010/011 are SUB/SUBB
    cap_c = (op == 4'h1 && ir[2:1] == 2'b00) || op == 4'h4 || (is_ctl && ctl == 12'h001);
    cap_b = (op == 4'h1 && ir[2:1] == 2'b01) || op == 4'h5 || (is_ctl && ctl == 12'h002);
  end
  always_comb begin
    state_nx = state == FETCH  ? (instr_valid_pi ? DECODE : FETCH) :
               state == DECODE ? (ctl_halt ? HALTED : EXEC) :
               state == EXEC   ? FETCH : HALTED;
  end
  always_comb begin
    instr_req_po = state == FETCH;
    instr_addr_po = pc;
    halted_po = state == HALTED;
    {arith_1op_po, arith_2op_po, addi_po, subi_po, load_or_store_po, stc_cmd_po, stb_cmd_po,
     rf_we_po, mem_rd_po, mem_wr_po, branch_po} = strb_q;
    alu_func_po = ir[2:0];
    immediate_po = ir[5:0];
    rd_po = ir[11:9];
    rs1_po = ir[8:6];
    rs2_po = ir[5:3];
    carry_flag_po = carry_q;
    borrow_flag_po = borrow_q;
  end
  always_ff @(posedge clk_pi) begin
    if (!reset_n_pi) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      carry_q <= 1'b0;
      borrow_q <= 1'b0;
      strb_q <= '0;
    end else begin
      state <= state_nx;
      strb_q <= state == DECODE ? strb_d : '0;
      if (state == FETCH && instr_valid_pi) begin
        ir <= instr_pi;
        pc <= pc + PC_W'(1);
      end
      if (state == EXEC) begin
        pc <= ctl_rst ? RESET_PC : pc;
        carry_q <= ctl_rst ? 1'b0 : cap_c ? alu_carry_pi : carry_q;
        borrow_q <= ctl_rst ? 1'b0 : cap_b ? alu_borrow_pi : borrow_q;
      end
    end
  end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed + randomized check of alu_ctrl_seq against an instruction-level model
module tb_alu_ctrl_seq;
  localparam logic [15:0] RPC = 16'hfff8;
  logic clk = 0, reset_n = 0;
  logic instr_req, instr_valid = 0, arith_1op, arith_2op, addi, subi, ls, stc, stb;
  logic [15:0] instr_addr, instr = 0;
  logic [2:0] alu_func, rd, rs1, rs2;
  logic [5:0] imm;
  logic carry_flag, borrow_flag, alu_carry = 0, alu_borrow = 0;
  logic rf_we, mem_rd, mem_wr, branch, halted;
  int vectors = 0, miscompares = 0;
  int pc_m;
  logic carry_m, borrow_m;
  logic [10:0] strb;
  logic [10:0] op_tbl [16];

  alu_ctrl_seq #(.PC_W(16), .RESET_PC(RPC)) dut (
    .clk_pi(clk), .reset_n_pi(reset_n), .instr_req_po(instr_req), .instr_addr_po(instr_addr),
    .instr_valid_pi(instr_valid), .instr_pi(instr), .arith_1op_po(arith_1op), .arith_2op_po(arith_2op),
    .addi_po(addi), .subi_po(subi), .load_or_store_po(ls), .stc_cmd_po(stc), .stb_cmd_po(stb),
    .alu_func_po(alu_func), .immediate_po(imm), .rd_po(rd), .rs1_po(rs1), .rs2_po(rs2),
    .carry_flag_po(carry_flag), .borrow_flag_po(borrow_flag), .alu_carry_pi(alu_carry),
    .alu_borrow_pi(alu_borrow), .rf_we_po(rf_we), .mem_rd_po(mem_rd), .mem_wr_po(mem_wr),
    .branch_po(branch), .halted_po(halted));

  assign strb = {arith_1op, arith_2op, addi, subi, ls, stc, stb, rf_we, mem_rd, mem_wr, branch};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] expect_strb(input logic [15:0] ins);
    logic [10:0] e;
    e = op_tbl[ins[15:12]];
    if (ins[15:12] == 4'hf) e = ins[11:0] == 12'h001 ? 11'b00000100000 :
                                ins[11:0] == 12'h002 ? 11'b00000010000 : 11'b0;
    return e;
  endfunction

  task automatic do_reset();
    reset_n = 0;
    instr_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_strb", 32'(strb), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_flags", {carry_flag, borrow_flag}, 0);
    chk("rst_addr", 32'(instr_addr), 32'(RPC));
    reset_n = 1;
    pc_m = int'(RPC);
    carry_m = 0;
    borrow_m = 0;
  endtask

  task automatic run(input logic [15:0] ins, input int dly, input logic c, input logic b);
    int fn;
    chk("fetch_req", 32'(instr_req), 1);
    chk("fetch_addr", 32'(instr_addr), 32'(pc_m));
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("wait_req", 32'(instr_req), 1);
      chk("wait_addr", 32'(instr_addr), 32'(pc_m));
      chk("wait_strb", 32'(strb), 0);
    end
    instr = ins;
    instr_valid = 1;
    @(negedge clk);
    instr_valid = 0;
    instr = 16'($urandom);
    pc_m = (pc_m + 1) % 65536;
    chk("dec_req", 32'(instr_req), 0);
    chk("dec_strb", 32'(strb), 0);
    alu_carry = c;
    alu_borrow = b;
    @(negedge clk);
    if (ins == 16'hffff) begin
      for (int i = 0; i < 20; i++) begin
        chk("halt_flag", 32'(halted), 1);
        chk("halt_req", 32'(instr_req), 0);
        chk("halt_strb", 32'(strb), 0);
        @(negedge clk);
      end
      return;
    end
    chk("exec_strb", 32'(strb), 32'(expect_strb(ins)));
    chk("exec_fields", {alu_func, imm, rd, rs1, rs2}, {ins[2:0], ins[5:0], ins[11:9], ins[8:6], ins[5:3]});
    fn = int'(ins[2:0]);
    if ((ins[15:12] == 1 && fn <= 1) || ins[15:12] == 4 || ins == 16'hf001) carry_m = c;
    if ((ins[15:12] == 1 && (fn == 2 || fn == 3)) || ins[15:12] == 5 || ins == 16'hf002) borrow_m = b;
    if (ins == 16'hfaaa) begin
      pc_m = int'(RPC);
      carry_m = 0;
      borrow_m = 0;
    end
    @(negedge clk);
    chk("flag_c", 32'(carry_flag), 32'(carry_m));
    chk("flag_b", 32'(borrow_flag), 32'(borrow_m));
    chk("exec_done_strb", 32'(strb), 0);
  endtask

  initial begin
    logic [15:0] ins;
    op_tbl = '{default: 11'b0};
    op_tbl[1] = 11'b01000001000;
    op_tbl[2] = 11'b10000001000;
    op_tbl[3] = 11'b00000001000;
    op_tbl[4] = 11'b00100001000;
    op_tbl[5] = 11'b00010001000;
    op_tbl[6] = 11'b00001000100;
    op_tbl[7] = 11'b00001000010;
    for (int i = 8; i <= 12; i++) op_tbl[i] = 11'b00000000001;
    do_reset();
    run(16'h1298, 0, 1, 0);
    chk("add_carry", 32'(carry_flag), 1);
    run(16'h3abc, 5, 0, 0);
    run(16'hf002, 1, 0, 1);
    run(16'h1004, 0, 1, 0);
    chk("and_keeps_borrow", 32'(borrow_flag), 1);
    run(16'h502a, 2, 0, 1);
    chk("subi_borrow", 32'(borrow_flag), 1);
    run(16'hfaaa, 0, 1, 1);
    chk("ctlrst_addr", 32'(instr_addr), 32'(RPC));
    for (int i = 0; i < 8; i++) run(16'h0000, 0, 0, 0);
    chk("pc_wrap", 32'(instr_addr), 0);
    for (int i = 0; i < 60; i++) begin
      ins = 16'($urandom);
      if (ins[15:12] == 4'hf) ins[11:0] = $urandom_range(0, 3) == 0 ? 12'h001 :
                                          $urandom_range(0, 2) == 0 ? 12'h002 :
                                          $urandom_range(0, 4) == 0 ? 12'haaa : 12'h123;
      run(ins, $urandom_range(0, 3), 1'($urandom), 1'($urandom));
    end
    run(16'hffff, 1, 0, 0);
    do_reset();
    run(16'hf001, 0, 1, 0);
    run(16'hf002, 0, 0, 1);
    instr = 16'h7000;
    instr_valid = 1;
    @(negedge clk);
    instr_valid = 0;
    @(negedge clk);
    chk("stor_wr", 32'(mem_wr), 1);
    reset_n = 0;
    @(negedge clk);
    chk("rst_exec_wr", 32'(mem_wr), 0);
    chk("rst_exec_req", 32'(instr_req), 1);
    chk("rst_exec_addr", 32'(instr_addr), 32'(RPC));
    chk("rst_exec_flags", {carry_flag, borrow_flag}, 0);
    reset_n = 1;
    pc_m = int'(RPC);
    carry_m = 0;
    borrow_m = 0;
    run(16'h4001, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
